counter_cmd_ctrl: RTL and testbench
===================================

// Module: counter_cmd_ctrl
// PURPOSE
//  Command source for the 4-bit up/down/load counter: converts raw push-buttons plus
//  a switch bank into single-cycle EN/S/D command pulses on the counter's command port.
//  Performs 2-FF synchronisation, per-button debounce, rising-edge detection, priority
//  arbitration and auto-repeat on held UP/DN. Sits between board I/O and the counter.
// PARAMETERS
//  WIDTH            4       data width of SW/D_O (matches counter D)
//  DEBOUNCE_CYCLES  4       consecutive stable cycles before debounced level changes (>=1)
//  REPEAT_DELAY     8       cycles from first command to first auto-repeat (>=1)
//  REPEAT_RATE      4       cycles between subsequent auto-repeat commands (>=1)
// PORTS
//  CLK     in   1      clock, rising edge
//  RST     in   1      reset, asynchronous, active-high
//  BTN_UP  in   1      raw async button, active-high: count up
//  BTN_DN  in   1      raw async button, active-high: count down
//  BTN_LD  in   1      raw async button, active-high: load SW
//  SW      in   WIDTH  load value; static, sampled at load-command time
//  EN_O    out  1      one-cycle command strobe to counter EN
//  S_O     out  2      command to counter S: 01 load, 10 up, 11 down; 00 when EN_O=0
//  D_O     out  WIDTH  load data to counter D; holds last loaded value
//  HOLD_O  out  1      high while in REPEAT state
// BEHAVIOUR
//  Reset: all outputs 0; sync FFs, debounce counters/levels, FSM (IDLE) and timers cleared.
//  Sync: each BTN_* through 2 FFs; debounce on synced level only.
//  Debounce: per button, counter increments while synced != debounced, else clears;
//   debounced level toggles when counter reaches DEBOUNCE_CYCLES; counter then clears.
//  Edge: rise = debounced & ~debounced_q (1 cycle).
//  Latency: BTN held from first sampling edge -> EN_O high exactly DEBOUNCE_CYCLES+3
//   edges later (2 sync + DEBOUNCE_CYCLES + 1 output register). All outputs registered.
//  FSM IDLE: on any rise, issue command, latch active button, go PRESS.
//   Priority on simultaneous rises: LD > UP > DN; losers dropped (no later command).
//  FSM PRESS: timer counts from command cycle. Active debounced low -> IDLE, no command.
//   Active=UP/DN and timer reaches REPEAT_DELAY -> issue command, go REPEAT, HOLD_O=1.
//   Active=LD: no repeat; waits for release only.
//  FSM REPEAT: command every REPEAT_RATE cycles while held; release -> IDLE, HOLD_O=0,
//   no command on the release cycle.
//  While not IDLE, rises on non-active buttons are ignored; no queueing. Non-active held
//   button does not fire on return to IDLE (requires fresh rise).
//  Load command: D_O <= SW in same cycle as EN_O=1,S_O=01; D_O unchanged otherwise.
//  EN_O never high two consecutive cycles when REPEAT_RATE>=2; REPEAT_RATE=1 -> every cycle.
//  Timers saturate; no wrap. Glitch shorter than DEBOUNCE_CYCLES -> no command.
//  RST mid-press: outputs drop immediately; button still held after RST release is
//   re-debounced from 0 and issues one fresh command after DEBOUNCE_CYCLES+3.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4, WIDTH=4)
//  Reset: RST=1 with buttons high -> EN_O=0,S_O=00,D_O=0,HOLD_O=0 asynchronously.
//  SW=4'hA, BTN_LD high 20 cycles -> single EN_O pulse at cycle 7, S_O=01, D_O=A;
//   no repeat, HOLD_O=0.
//  BTN_UP held 30 cycles -> EN_O/S_O=10 at cycles 7,15,19,23,27,31; HOLD_O high from 15
//   until release+debounce; counter reference model shows +6.
//  BTN_UP,BTN_DN,BTN_LD rise same edge -> exactly one pulse S_O=01; UP/DN never fire
//   until released and re-pressed.
//  BTN_DN pulses of 3 cycles high/3 low (bounce) then steady -> no command during bounce;
//   one S_O=11 pulse DEBOUNCE_CYCLES+3 after steady high.
//  BTN_DN held into REPEAT, RST pulsed 1 cycle -> outputs 0; one fresh S_O=11 7 cycles
//   after RST release, then repeat resumes at +8.

Source files
------------

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - push-button command source for the up/down/load counter
// Sync, debounce and edge-detect three buttons, then arbitrate and auto-repeat into EN/S/D strobes.
module counter_cmd_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    input  logic             BTN_LD,
    input  logic [WIDTH-1:0] SW,
    output logic             EN_O,
    output logic [1:0]       S_O,
    output logic [WIDTH-1:0] D_O,
    output logic             HOLD_O
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] B_UP = 2'd0;
    localparam logic [1:0] B_DN = 2'd1;
    localparam logic [1:0] B_LD = 2'd2;

    localparam logic [1:0] S_LD = 2'b01;
    localparam logic [1:0] S_UP = 2'b10;
    localparam logic [1:0] S_DN = 2'b11;

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

    state_t        state, next_state;
    logic [1:0]    active, next_active;
    logic [TW-1:0] timer;
    logic          cmd;
    logic [1:0]    cmd_s;
    logic          act_level;

    logic [2:0]    raw, sync1, sync2, db, db_q, rise;
    logic [CW-1:0] db_cnt [3];

    assign raw = {BTN_LD, BTN_DN, BTN_UP};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise      = db & ~db_q;
    assign act_level = db[active];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            active <= B_UP;
        end else begin
            state  <= next_state;
            active <= next_active;
        end
    end

    always_comb begin
        next_state  = state;
        next_active = active;
        case (state)
            IDLE: begin
                if (|rise) begin
                    next_state  = PRESS;
                    next_active = rise[B_LD] ? B_LD : (rise[B_UP] ? B_UP : B_DN);
                end
            end
            PRESS: begin
                if (!act_level)
                    next_state = IDLE;
                else if (cmd)
                    next_state = REPEAT;
            end
            REPEAT: begin
                if (!act_level)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd   = 1'b0;
        cmd_s = 2'b00;
        case (state)
            IDLE: begin
                if (rise[B_LD]) begin
                    cmd   = 1'b1;
                    cmd_s = S_LD;
                end else if (rise[B_UP]) begin
                    cmd   = 1'b1;
                    cmd_s = S_UP;
                end else if (rise[B_DN]) begin
                    cmd   = 1'b1;
                    cmd_s = S_DN;
                end
            end
            PRESS: begin
                if (act_level && active != B_LD && timer == TW'(REPEAT_DELAY)) begin
                    cmd   = 1'b1;
                    cmd_s = (active == B_UP) ? S_UP : S_DN;
                end
            end
            REPEAT: begin
                if (act_level && timer == TW'(REPEAT_RATE)) begin
                    cmd   = 1'b1;
                    cmd_s = (active == B_UP) ? S_UP : S_DN;
                end
            end
            default: ;
        endcase
    end

    // Timer reads 1 in the cycle after a command, so it equals the gap on the next one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            timer <= '0;
        else if (cmd)
            timer <= TW'(1);
        else if (timer != '1)
            timer <= timer + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EN_O   <= 1'b0;
            S_O    <= 2'b00;
            D_O    <= '0;
            HOLD_O <= 1'b0;
        end else begin
            EN_O   <= cmd;
            S_O    <= cmd_s;
            HOLD_O <= (next_state == REPEAT);
            if (cmd && cmd_s == S_LD)
                D_O <= SW;
        end
    end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - directed and random check of counter_cmd_ctrl against an edge-indexed model
module tb_counter_cmd_ctrl;

    localparam int W    = 4;
    localparam int DC   = 4;
    localparam int RD   = 8;
    localparam int RR   = 4;
    localparam int MAXN = 4096;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         BTN_UP = 1'b0, BTN_DN = 1'b0, BTN_LD = 1'b0;
    logic [W-1:0] SW = '0;
    logic         EN_O;
    logic [1:0]   S_O;
    logic [W-1:0] D_O;
    logic         HOLD_O;

    counter_cmd_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
        .SW(SW), .EN_O(EN_O), .S_O(S_O), .D_O(D_O), .HOLD_O(HOLD_O)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int en_count = 0;

    // Model: raw/debounced level per button per edge since reset (index 0 = 0 after reset).
    bit           raw_h [3][MAXN];
    bit           db_h  [3][MAXN];
    bit           m_busy;
    int           m_act, m_last, m_ncmd;
    logic [W-1:0] e_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit raw_at(input int b, input int i);
        return (i < 1) ? 1'b0 : raw_h[b][i];
    endfunction

    function automatic bit db_at(input int b, input int i);
        return (i < 1) ? 1'b0 : db_h[b][i];
    endfunction

    function automatic logic [1:0] code(input int b);
        return (b == 2) ? 2'b01 : ((b == 0) ? 2'b10 : 2'b11);
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_busy = 0;
        m_ncmd = 0;
        m_act  = 0;
        m_last = 0;
        e_d    = '0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < MAXN; i++) begin
                raw_h[b][i] = 1'b0;
                db_h[b][i]  = 1'b0;
            end
    endtask

    task automatic step();
        bit           flip, e_en, e_hold;
        logic [1:0]   e_s;
        logic [W-1:0] sw_now;
        int           pick, gap;
        @(posedge CLK);
        edge_n++;
        if (edge_n >= MAXN) begin
            $display("FAIL model_range: got %0d expected below %0d", edge_n, MAXN);
            $fatal(1);
        end
        raw_h[0][edge_n] = BTN_UP;
        raw_h[1][edge_n] = BTN_DN;
        raw_h[2][edge_n] = BTN_LD;
        sw_now = SW;
        // synced input seen at edge n is the raw value two edges earlier
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DC; j++)
                if (raw_at(b, edge_n - 2 - j) == db_at(b, edge_n - 1)) flip = 1'b0;
            db_h[b][edge_n] = flip ? ~db_at(b, edge_n - 1) : db_at(b, edge_n - 1);
        end
        e_en = 1'b0;
        e_s  = 2'b00;
        if (!m_busy) begin
            pick = -1;
            if (db_at(2, edge_n - 1) && !db_at(2, edge_n - 2))      pick = 2;
            else if (db_at(0, edge_n - 1) && !db_at(0, edge_n - 2)) pick = 0;
            else if (db_at(1, edge_n - 1) && !db_at(1, edge_n - 2)) pick = 1;
            if (pick >= 0) begin
                m_busy = 1; m_act = pick; m_last = edge_n; m_ncmd = 1;
                e_en = 1'b1; e_s = code(pick);
            end
        end else if (!db_at(m_act, edge_n - 1)) begin
            m_busy = 0;
            m_ncmd = 0;
        end else if (m_act != 2) begin
            gap = (m_ncmd == 1) ? RD : RR;
            if (edge_n - m_last == gap) begin
                e_en = 1'b1; e_s = code(m_act); m_last = edge_n; m_ncmd++;
            end
        end
        if (e_en && m_act == 2) e_d = sw_now;
        e_hold = m_busy && (m_ncmd >= 2);
        #1;
        check("en", EN_O, e_en);
        check("s", S_O, e_s);
        check("d", D_O, e_d);
        check("hold", HOLD_O, e_hold);
        if (EN_O === 1'b1) en_count++;
    endtask

    task automatic hold_btns(input bit up, input bit dn, input bit ld, input int cycles);
        BTN_UP = up; BTN_DN = dn; BTN_LD = ld;
        repeat (cycles) step();
    endtask

    task automatic apply_reset(input int cycles);
        RST = 1'b1;
        #1;
        check("rst_en", EN_O, 1'b0);
        check("rst_s", S_O, 2'b00);
        check("rst_d", D_O, '0);
        check("rst_hold", HOLD_O, 1'b0);
        repeat (cycles) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        BTN_UP = 1'b1; BTN_DN = 1'b1; BTN_LD = 1'b1;
        #2;
        apply_reset(3);
        hold_btns(0, 0, 0, 5);

        SW = 4'hA;
        en_count = 0;
        hold_btns(0, 0, 1, 20);
        hold_btns(0, 0, 0, 15);
        check("ld_pulses", en_count, 1);
        check("ld_data", D_O, 4'hA);

        apply_reset(1);
        en_count = 0;
        hold_btns(1, 0, 0, 27);
        hold_btns(0, 0, 0, 15);
        check("up_pulses", en_count, 6);

        apply_reset(1);
        en_count = 0;
        SW = 4'h5;
        hold_btns(1, 1, 1, 20);
        hold_btns(1, 1, 0, 20);
        hold_btns(0, 0, 0, 15);
        check("simul_pulses", en_count, 1);
        hold_btns(1, 0, 0, 10);
        hold_btns(0, 0, 0, 15);

        en_count = 0;
        for (int k = 0; k < 4; k++) begin
            hold_btns(0, 1, 0, 3);
            hold_btns(0, 0, 0, 3);
        end
        check("bounce_pulses", en_count, 0);
        hold_btns(0, 1, 0, 12);
        hold_btns(0, 0, 0, 15);

        hold_btns(0, 1, 0, 20);
        apply_reset(1);
        hold_btns(0, 1, 0, 20);
        hold_btns(0, 0, 0, 15);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) BTN_UP = ~BTN_UP;
            if ($urandom_range(0, 9) == 0) BTN_DN = ~BTN_DN;
            if ($urandom_range(0, 11) == 0) BTN_LD = ~BTN_LD;
            if ($urandom_range(0, 15) == 0) SW = W'($urandom);
            if ($urandom_range(0, 399) == 0) apply_reset($urandom_range(1, 2));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
